reg_file_multiport: RTL and testbench
=====================================

# reg_file_multiport

Parametrised multi-port register file: DEPTH = 2^ADDR_WIDTH words of DATA_WIDTH bits, one synchronous write port and NUM_RD independent combinational read ports. It is the next-generation register file for the processor datapath. It replaces per-bit storage cells and shared bitlines with word storage and per-port read muxes. It adds three behaviours:
- write-to-read bypass
- an optional hardwired zero register
- a sequenced bulk-clear engine with a busy/done handshake

## Interface
- DATA_WIDTH, 16, bits per word
- ADDR_WIDTH, 4, address bits; DEPTH = 2^ADDR_WIDTH
- NUM_RD, 2, number of read ports (≥1)
- ZERO_REG, 1, when 1 entry 0 always reads 0 and ignores writes
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- wr_en  in  1  write enable
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- rd_addr  in  NUM_RD*ADDR_WIDTH  read port i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
- rd_data  out  NUM_RD*DATA_WIDTH  read port i data at [i*DATA_WIDTH +: DATA_WIDTH]
- clr_req  in  1  request bulk clear of all entries
- clr_busy  out  1  clear engine active; writes blocked
- clr_done  out  1  one-cycle pulse when clear completes

## Operation
- **Write:** when wr_en=1 and state is IDLE, mem[wr_addr] ← wr_data at the clock edge.
  - If ZERO_REG=1 and wr_addr=0, the write is dropped.
- **Read:** each port i is combinational. rd_data[i] = mem[rd_addr[i]] with the following overrides:
  - **Zero register:** ZERO_REG=1 and rd_addr[i]=0 → 0.
  - **Bypass:** state IDLE, wr_en=1, wr_addr=rd_addr[i], and the write is not dropped → wr_data.
  - All ports are independent. Any number of ports may read the same address.
- **Clear FSM states:** IDLE, CLEAR, DONE.
  - IDLE: clr_req=1 at an edge → CLEAR with idx←0.
  - CLEAR: mem[idx] ← 0 and idx ← idx+1 each edge. When idx=DEPTH-1 is written → DONE.
  - DONE: one cycle, then → IDLE.
  - clr_busy=1 in CLEAR and DONE. clr_done=1 in DONE only.
- **During CLEAR/DONE:**
  - wr_en is ignored and no bypass is applied.
  - Reads return stored contents, so already-cleared entries read 0 and uncleared entries read their old value.
  - clr_req is ignored; requests are not queued.
- **wr_en and clr_req together in IDLE:** the write commits at that same edge, then the clear sequence overwrites it.
- **idx width:** ADDR_WIDTH bits. The terminal compare is on DEPTH-1, with no wrap past it.

## Timing
- **Reset values** (rst=0, asynchronous, takes effect immediately):
  - all mem entries 0
  - state IDLE, idx 0
  - clr_busy 0, clr_done 0
  - rd_data therefore 0 on all ports
- **Reset during CLEAR** aborts the sequence. All entries are 0 and state is IDLE; no clr_done pulse.
- **Write latency:** data is visible through storage from the cycle after the write edge, and via bypass in the same cycle.
- **Read latency:** 0 cycles, combinational from rd_addr, wr_* and state.
- **Clear latency:** clr_req sampled at edge T.
  - clr_busy=1 from T+1 through T+DEPTH+1.
  - Entry k is zero after edge T+1+k.
  - clr_done=1 during the cycle after edge T+DEPTH.
  - IDLE again after edge T+DEPTH+1; writes are accepted at that edge's successor.
- Total clear cost: DEPTH+1 busy cycles.

## Test plan
- **Reset:** assert rst=0 mid-simulation → all rd_data 0, clr_busy 0, clr_done 0, independent of clk.
- **Write/read:** write 0xBEEF to addr 5, next cycle rd_addr port0=5, port1=5 → both read 0xBEEF. Write to addr 0 with ZERO_REG=1 → port reads 0x0000.
- **Bypass:** mem[3]=0x1111. In one cycle wr_en=1, wr_addr=3, wr_data=0x2222, port0=3, port1=4 → port0 reads 0x2222, port1 reads mem[4]. After the edge, port0 still reads 0x2222.
- **Bulk clear:** fill all 16 entries with nonzero values, pulse clr_req.
  - clr_busy high 17 cycles; clr_done high exactly 1 cycle.
  - Mid-sequence, entry k reads 0 only after its edge.
  - Writes issued while busy are dropped; afterwards all entries read 0.
- **Corner:** clr_req with simultaneous write of 0xAAAA to addr 7 → addr 7 reads 0 after clear. A second clr_req while busy → no extra cycles.
- **Reset mid-clear:** rst=0 at clear cycle 6 → state IDLE, clr_busy 0, no clr_done, all entries 0. A new clr_req after release runs a full sequence.

Source files
------------

// File: rtl/reg_file_multiport.sv
// reg_file_multiport: word-storage register file, one write port,
// NUM_RD combinational read ports, bypass, zero register, bulk clear.
module reg_file_multiport #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_RD     = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  input  logic                         clr_req,
  output logic                         clr_busy,
  output logic                         clr_done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } state_t;

  state_t                state;
  state_t                state_nx;
  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH-1:0] idx_nx;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wr_drop;
  logic                  wr_ok;

  assign wr_drop = (ZERO_REG != 0) && (wr_addr == '0);
  assign wr_ok   = (state == IDLE) && wr_en && !wr_drop;

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    unique case (state)
      IDLE: begin
        if (clr_req) begin
          state_nx = CLEAR;
          idx_nx   = '0;
        end
      end
      CLEAR: begin
        // terminal entry holds idx; no wrap back to 0
        if (idx == ADDR_WIDTH'(DEPTH - 1)) begin
          state_nx = DONE;
        end else begin
          idx_nx = idx + 1'b1;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      if (state == CLEAR) begin
        mem[idx] <= '0;
      end else if (wr_ok) begin
        mem[wr_addr] <= wr_data;
      end
    end
  end

  assign clr_busy = (state != IDLE);
  assign clr_done = (state == DONE);

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    assign ra = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] =
      ((ZERO_REG != 0) && (ra == '0)) ? '0 :
      (wr_ok && (wr_addr == ra))      ? wr_data :
                                        mem[ra];
  end

endmodule

// File: tb/tb_reg_file_multiport.sv
// tb_reg_file_multiport: directed stimulus with a scoreboard queue
// drained by a negedge monitor.
module tb_reg_file_multiport;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [3:0]  ra0;
  logic [3:0]  ra1;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic        clr_req;
  logic        clr_busy;
  logic        clr_done;

  assign rd_addr = {ra1, ra0};

  reg_file_multiport #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(4),
    .NUM_RD    (2),
    .ZERO_REG  (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .clr_req (clr_req),
    .clr_busy(clr_busy),
    .clr_done(clr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t sbq[$];
  logic chk_req = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  // kind: 0 port0, 1 port1, 2 clr_busy, 3 clr_done
  initial begin
    forever begin
      @(negedge clk);
      if (chk_req) begin
        while (sbq.size() > 0) begin
          exp_t        e;
          logic [15:0] act;
          e = sbq.pop_front();
          case (e.kind)
            0:       act = rd_data[15:0];
            1:       act = rd_data[31:16];
            2:       act = {15'd0, clr_busy};
            default: act = {15'd0, clr_done};
          endcase
          n_chk++;
          if (act === e.val) n_pass++;
          else $display("FAIL %s: got %h want %h", e.name, act, e.val);
        end
      end
    end
  end

  task automatic exp(input int k, input logic [15:0] v, input string nm);
    exp_t e;
    e.kind = k;
    e.val  = v;
    e.name = nm;
    sbq.push_back(e);
  endtask

  task automatic sample();
    chk_req = 1'b1;
    @(negedge clk);
    #1 chk_req = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic clear_run(input int req_at, input logic [3:0] a,
                           input logic [15:0] old);
    for (int c = 0; c <= 17; c++) begin
      clr_req = (c == req_at);
      ra0 = a;
      exp(2, (c <= 16) ? 16'd1 : 16'd0, $sformatf("busy c%0d", c));
      exp(3, (c == 16) ? 16'd1 : 16'd0, $sformatf("done c%0d", c));
      exp(0, (int'(a) < c) ? 16'h0 : old, $sformatf("entry c%0d", c));
      sample();
      tick();
    end
    clr_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    ra0 = 4'd5; ra1 = 4'd9; clr_req = 1'b0;
    #12 rst = 1'b1;
    tick();

    n_chk++;
    if (rd_data === 32'h0) n_pass++;
    else $display("FAIL reset rd: got %h want 0", rd_data);
    n_chk++;
    if (clr_busy === 1'b0) n_pass++;
    else $display("FAIL reset busy: got %b want 0", clr_busy);
    n_chk++;
    if (clr_done === 1'b0) n_pass++;
    else $display("FAIL reset done: got %b want 0", clr_done);

    exp(0, 16'h0, "reset p0");
    exp(1, 16'h0, "reset p1");
    exp(2, 16'h0, "reset busy");
    exp(3, 16'h0, "reset done");
    sample();

    tick();
    wr(4'd5, 16'hBEEF);
    ra0 = 4'd5; ra1 = 4'd5;
    #1;
    n_chk++;
    if (rd_data === 32'hBEEFBEEF) n_pass++;
    else $display("FAIL wr5 direct: got %h want beefbeef", rd_data);
    exp(0, 16'hBEEF, "wr5 p0");
    exp(1, 16'hBEEF, "wr5 p1");
    sample();

    tick();
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h1234; ra0 = 4'd0;
    exp(0, 16'h0, "zero nobypass");
    sample();
    tick();
    wr_en = 1'b0;
    exp(0, 16'h0, "zero stored");
    sample();

    tick();
    wr(4'd3, 16'h1111);
    wr(4'd4, 16'h4444);
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h2222;
    ra0 = 4'd3; ra1 = 4'd4;
    exp(0, 16'h2222, "bypass p0");
    exp(1, 16'h4444, "bypass p1");
    sample();
    tick();
    wr_en = 1'b0;
    exp(0, 16'h2222, "bypass after");
    sample();

    tick();
    for (int i = 1; i < 16; i++) wr(4'(i), 16'h1000 + 16'(i));
    clr_req = 1'b1;
    exp(2, 16'h0, "busy pre");
    sample();
    tick();
    clr_req = 1'b0;
    for (int c = 0; c <= 17; c++) begin
      wr_en = (c <= 16); wr_addr = 4'd15; wr_data = 16'hDEAD;
      clr_req = (c == 5);
      ra0 = 4'((c + 15) % 16);
      ra1 = (c <= 15) ? 4'(c) : 4'd15;
      exp(2, (c <= 16) ? 16'd1 : 16'd0, $sformatf("bulk busy c%0d", c));
      exp(3, (c == 16) ? 16'd1 : 16'd0, $sformatf("bulk done c%0d", c));
      if (c >= 1) exp(0, 16'h0, $sformatf("bulk cleared c%0d", c));
      if (c == 0) exp(1, 16'h0, "bulk pending c0");
      else if (c <= 15)
        exp(1, 16'h1000 + 16'(c), $sformatf("bulk pending c%0d", c));
      else exp(1, 16'h0, $sformatf("bulk last c%0d", c));
      if (c == 17) wr_en = 1'b0;
      sample();
      tick();
    end
    wr_en = 1'b0; clr_req = 1'b0;
    for (int i = 0; i < 16; i += 2) begin
      ra0 = 4'(i); ra1 = 4'(i + 1);
      exp(0, 16'h0, $sformatf("post clr %0d", i));
      exp(1, 16'h0, $sformatf("post clr %0d", i + 1));
      sample();
    end

    tick();
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'hAAAA; clr_req = 1'b1;
    tick();
    wr_en = 1'b0; clr_req = 1'b0;
    clear_run(3, 4'd7, 16'hAAAA);
    ra0 = 4'd7;
    exp(0, 16'h0, "corner addr7");
    sample();

    tick();
    wr(4'd9, 16'h5555);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    ra0 = 4'd9; ra1 = 4'd12;
    rst = 1'b0;
    #1;
    n_chk++;
    if (clr_busy === 1'b0) n_pass++;
    else $display("FAIL abort busy direct: got %b want 0", clr_busy);
    n_chk++;
    if (clr_done === 1'b0) n_pass++;
    else $display("FAIL abort done direct: got %b want 0", clr_done);
    n_chk++;
    if (rd_data === 32'h0) n_pass++;
    else $display("FAIL abort rd direct: got %h want 0", rd_data);
    exp(2, 16'h0, "abort busy");
    exp(3, 16'h0, "abort done");
    exp(0, 16'h0, "abort e9");
    exp(1, 16'h0, "abort e12");
    sample();
    tick();
    rst = 1'b1;
    for (int c = 0; c < 18; c++) begin
      exp(3, 16'h0, $sformatf("no done c%0d", c));
      sample();
      tick();
    end
    wr(4'd12, 16'h7777);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    clear_run(-1, 4'd12, 16'h7777);

    tick();
    if (n_pass != n_chk)
      $display("FAIL summary: got %0d want %0d", n_pass, n_chk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
